// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter and its prescaler.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_PRESCALE_W = 4;

endpackage : counter_pkg

// File: rtl/tick_prescaler.sv
// Enable-gated clock divider: one tick every (prescale+1) enabled cycles.
// restart forces the divider back to the start of a period.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  restart,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] div_cnt_q;
    logic [PRESCALE_W-1:0] div_cnt_d;

    // Using >= rather than == means lowering prescale below the current
    // phase fires on the next enabled cycle instead of running the divider
    // all the way round.
    always_comb begin
        tick      = en && (div_cnt_q >= prescale);
        div_cnt_d = div_cnt_q;
        if (restart) begin
            div_cnt_d = '0;
        end else if (tick) begin
            div_cnt_d = '0;
        end else if (en) begin
            div_cnt_d = div_cnt_q + PRESCALE_W'(1);
        end
    end

    // Divider phase register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule : tick_prescaler

// File: rtl/updown_counter_ctl.sv
// Parametrised up/down counter with prescaler, load, wrap/saturate mode,
// compare match, terminal-count pulse and sticky overflow flag.
module updown_counter_ctl
    import counter_pkg::*;
#(
    parameter int                     WIDTH      = DEF_WIDTH,
    parameter int                     PRESCALE_W = DEF_PRESCALE_W,
    parameter logic [WIDTH-1:0]       RESET_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  dir,
    input  logic                  sat_mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      cmp_val,
    input  logic                  clr_ovf,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  match,
    output logic                  ovf_sticky
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic             tick;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] stepped;
    logic             at_limit;

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .restart  (load),
        .prescale (prescale),
        .tick     (tick)
    );

    // Next count and terminal-count: load beats a tick; at a limit, wrap
    // mode takes the modulo step while saturate mode holds.
    always_comb begin
        stepped  = (dir == DIR_UP) ? (count_q + CNT_ONE) : (count_q - CNT_ONE);
        at_limit = (dir == DIR_UP) ? (count_q == CNT_MAX) : (count_q == '0);
        count_d  = count_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (tick) begin
            if (at_limit) begin
                tc_d = 1'b1;
                if (sat_mode == MODE_WRAP) begin
                    count_d = stepped;
                end
            end else begin
                count_d = stepped;
            end
        end
    end

    // Sticky overflow: a new terminal count wins over a coincident clear.
    always_comb begin
        ovf_d = tc_d | (ovf_q & ~clr_ovf);
    end

    // Count, tc and overflow registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= RESET_VAL;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count      = count_q;
    assign tc         = tc_q;
    assign ovf_sticky = ovf_q;
    assign match      = (count_q == cmp_val);

endmodule : updown_counter_ctl

// File: tb/tb_updown_counter_ctl.sv
// Self-checking bench for updown_counter_ctl with a behavioural reference model.
module tb_updown_counter_ctl;

    localparam int W     = 8;
    localparam int PW    = 4;
    localparam int RV    = 0;
    localparam int MAXV  = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          load;
    logic [W-1:0]  load_val;
    logic          dir;
    logic          sat_mode;
    logic [PW-1:0] prescale;
    logic [W-1:0]  cmp_val;
    logic          clr_ovf;
    logic [W-1:0]  count;
    logic          tc;
    logic          match;
    logic          ovf_sticky;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int m_count;
    int m_div;
    bit m_tc;
    bit m_ovf;

    always #5 clk = ~clk;

    updown_counter_ctl #(
        .WIDTH      (W),
        .PRESCALE_W (PW),
        .RESET_VAL  (W'(RV))
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .load_val   (load_val),
        .dir        (dir),
        .sat_mode   (sat_mode),
        .prescale   (prescale),
        .cmp_val    (cmp_val),
        .clr_ovf    (clr_ovf),
        .count      (count),
        .tc         (tc),
        .match      (match),
        .ovf_sticky (ovf_sticky)
    );

    // Advance the model by one edge using current inputs, then pass the edge.
    task automatic cycle();
        int nc, ndiv, target;
        bit ntc, tick;
        if (!rst_n) begin
            nc = RV; ndiv = 0; ntc = 0;
        end else begin
            tick = en && (m_div >= int'(prescale));
            nc   = m_count;
            ntc  = 0;
            if (load) begin
                nc   = int'(load_val);
                ndiv = 0;
            end else begin
                ndiv = tick ? 0 : (en ? m_div + 1 : m_div);
                if (tick) begin
                    target = m_count + (dir ? 1 : -1);
                    if (target < 0 || target > MAXV) begin
                        ntc = 1;
                        nc  = sat_mode ? m_count : ((target + MAXV + 1) % (MAXV + 1));
                    end else begin
                        nc = target;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        m_ovf   = rst_n ? (ntc || (m_ovf && !clr_ovf)) : 1'b0;
        m_count = nc;
        m_div   = ndiv;
        m_tc    = ntc;
    endtask

    function automatic logic [W+2:0] expv();
        logic [W-1:0] mc;
        mc = m_count[W-1:0];
        return {mc, m_tc, (mc == cmp_val), m_ovf};
    endfunction

    task automatic idle_inputs();
        en = 0; load = 0; load_val = '0; dir = 1; sat_mode = 0;
        prescale = '0; cmp_val = '0; clr_ovf = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        en = 1; load = 1; load_val = 8'hAA;
        cycle();
        cycle();
        vectors++;
        if ({count, tc, ovf_sticky} !== {W'(RV), 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: got count=%h tc=%b ovf=%b, want count=%h tc=0 ovf=0",
                     count, tc, ovf_sticky, W'(RV));
        end
        idle_inputs();
        rst_n = 1;
    endtask

    task automatic test_count_up();
        en = 1; dir = 1; prescale = 0; sat_mode = 0;
        for (int i = 0; i < 256; i++) begin
            cycle();
            vectors++;
            if ({count, tc, match, ovf_sticky} !== expv()) begin
                miscompares++;
                $display("FAIL count_up[%0d]: got %h/%b/%b/%b want %h", i, count, tc, match, ovf_sticky, expv());
            end
        end
        vectors++;
        if ({count, tc} !== {8'h00, 1'b1}) begin
            miscompares++;
            $display("FAIL count_up_wrap: got count=%h tc=%b, want 00/1", count, tc);
        end
        cycle();
        vectors++;
        if ({count, tc, ovf_sticky} !== {8'h01, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL count_up_after: got count=%h tc=%b ovf=%b, want 01/0/1", count, tc, ovf_sticky);
        end
    endtask

    task automatic test_prescale_en();
        load = 1; load_val = 8'h00; en = 1; dir = 1; prescale = 3;
        cycle();
        load = 0;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            vectors++;
            if ({count, tc, match, ovf_sticky} !== expv()) begin
                miscompares++;
                $display("FAIL prescale[%0d]: got %h/%b/%b/%b want %h", i, count, tc, match, ovf_sticky, expv());
            end
            if (i == 3 || i == 4) begin
                vectors++;
                if (count !== ((i == 4) ? 8'h01 : 8'h00)) begin
                    miscompares++;
                    $display("FAIL prescale_edge[%0d]: got count=%h want %h", i, count, (i == 4) ? 8'h01 : 8'h00);
                end
            end
        end
        en = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            vectors++;
            if ({count, tc, match, ovf_sticky} !== expv()) begin
                miscompares++;
                $display("FAIL freeze[%0d]: got %h/%b/%b/%b want %h", i, count, tc, match, ovf_sticky, expv());
            end
        end
        en = 1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            vectors++;
            if ({count, tc, match, ovf_sticky} !== expv()) begin
                miscompares++;
                $display("FAIL resume[%0d]: got %h/%b/%b/%b want %h", i, count, tc, match, ovf_sticky, expv());
            end
        end
    endtask

    task automatic test_sat_down();
        load = 1; load_val = 8'h05; dir = 0; sat_mode = 1; prescale = 0; en = 1;
        cycle();
        load = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            vectors++;
            if ({count, tc, match, ovf_sticky} !== expv()) begin
                miscompares++;
                $display("FAIL sat_down[%0d]: got %h/%b/%b/%b want %h", i, count, tc, match, ovf_sticky, expv());
            end
        end
        vectors++;
        if ({count, tc} !== {8'h00, 1'b1}) begin
            miscompares++;
            $display("FAIL sat_hold: got count=%h tc=%b, want 00/1", count, tc);
        end
        sat_mode = 0;
        cycle();
        vectors++;
        if ({count, tc} !== {8'hFF, 1'b1}) begin
            miscompares++;
            $display("FAIL wrap_down: got count=%h tc=%b, want ff/1", count, tc);
        end
    endtask

    task automatic test_load_tick();
        logic [W-1:0] lv;
        int guard;
        dir = 1; sat_mode = 0; prescale = 2; en = 1;
        guard = 0;
        while (m_div != 2 && guard < 10) begin
            cycle();
            guard++;
        end
        vectors++;
        if (m_div != 2) begin
            miscompares++;
            $display("FAIL load_tick_sync: phase not reached, got %0d want 2", m_div);
        end
        lv = W'($urandom_range(16, 200));
        load = 1; load_val = lv;
        cycle();
        load = 0;
        vectors++;
        if ({count, tc} !== {lv, 1'b0}) begin
            miscompares++;
            $display("FAIL load_beats_tick: got count=%h tc=%b, want %h/0", count, tc, lv);
        end
        for (int i = 1; i <= 3; i++) begin
            cycle();
            vectors++;
            if (count !== ((i == 3) ? lv + 8'h01 : lv)) begin
                miscompares++;
                $display("FAIL load_restart[%0d]: got count=%h want %h", i, count, (i == 3) ? lv + 8'h01 : lv);
            end
        end
    endtask

    task automatic test_match_ovf();
        cmp_val = 8'h10; dir = 1; sat_mode = 0; prescale = 0; en = 1;
        load = 1; load_val = 8'h0E; clr_ovf = 1;
        cycle();
        load = 0; clr_ovf = 0;
        vectors++;
        if (ovf_sticky !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_on_load: got ovf=%b want 0", ovf_sticky);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            vectors++;
            if ({count, tc, match, ovf_sticky} !== expv()) begin
                miscompares++;
                $display("FAIL match[%0d]: got %h/%b/%b/%b want %h", i, count, tc, match, ovf_sticky, expv());
            end
            if (count == 8'h10) begin
                vectors++;
                if (match !== 1'b1) begin
                    miscompares++;
                    $display("FAIL match_hit: got match=%b want 1", match);
                end
            end
        end
        load = 1; load_val = 8'hFF;
        cycle();
        load = 0; clr_ovf = 1;
        cycle();
        vectors++;
        if ({count, tc, ovf_sticky} !== {8'h00, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL set_beats_clr: got count=%h tc=%b ovf=%b, want 00/1/1", count, tc, ovf_sticky);
        end
        cycle();
        clr_ovf = 0;
        vectors++;
        if ({tc, ovf_sticky} !== 2'b00) begin
            miscompares++;
            $display("FAIL clr_alone: got tc=%b ovf=%b, want 0/0", tc, ovf_sticky);
        end
    endtask

    task automatic test_mid_reset();
        int guard;
        prescale = 2; dir = 1; sat_mode = 0; en = 1;
        load = 1; load_val = 8'hFF;
        cycle();
        load = 0;
        cycle(); cycle(); cycle();
        load = 1; load_val = 8'h78;
        cycle();
        load = 0;
        guard = 0;
        while (m_count != 8'h7A && guard < 20) begin
            cycle();
            guard++;
        end
        vectors++;
        if (count !== 8'h7A) begin
            miscompares++;
            $display("FAIL mid_reset_reach: got count=%h want 7a", count);
        end
        rst_n = 0;
        cycle();
        rst_n = 1;
        vectors++;
        if ({count, tc, ovf_sticky} !== {W'(RV), 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset: got count=%h tc=%b ovf=%b, want %h/0/0", count, tc, ovf_sticky, W'(RV));
        end
        for (int i = 1; i <= 3; i++) begin
            cycle();
            vectors++;
            if (count !== ((i == 3) ? W'(RV + 1) : W'(RV))) begin
                miscompares++;
                $display("FAIL reset_release[%0d]: got count=%h want %h", i, count, (i == 3) ? W'(RV + 1) : W'(RV));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(0, 63) != 0);
            en       = ($urandom_range(0, 3) != 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? 8'hFE : 8'h01)
                                                   : W'($urandom);
            dir      = ($urandom_range(0, 7) != 0) ? dir : ~dir;
            sat_mode = ($urandom_range(0, 15) != 0) ? sat_mode : ~sat_mode;
            if ($urandom_range(0, 31) == 0) prescale = PW'($urandom_range(0, 3));
            cmp_val  = ($urandom_range(0, 1) != 0) ? m_count[W-1:0] : W'($urandom);
            clr_ovf  = ($urandom_range(0, 7) == 0);
            cycle();
            vectors++;
            if ({count, tc, match, ovf_sticky} !== expv()) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h/%b/%b/%b want %h", i, count, tc, match, ovf_sticky, expv());
            end
        end
    endtask

    initial begin
        m_count = RV; m_div = 0; m_tc = 0; m_ovf = 0;
        test_reset();
        test_count_up();
        test_prescale_en();
        test_sat_down();
        test_load_tick();
        test_match_ovf();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_updown_counter_ctl
